// File: rtl/noc_pkg.sv
// NoC packet definitions shared by the slave-side read bridge and its helpers.
// Contents: flit type encodings, packet type encodings, the head-flit header
// layout (MSB-aligned in the payload) and the flit width helper.
package noc_pkg;

    // Flit type field, bits [FLIT_W-2 -: 2] of a flit
    typedef enum logic [1:0] {
        FtBody   = 2'b00,
        FtHead   = 2'b01,
        FtTail   = 2'b10,
        FtSingle = 2'b11
    } ftype_e;

    localparam logic [2:0] PktRdReq  = 3'b011;
    localparam logic [2:0] PktRdResp = 3'b101;

    localparam int unsigned NocNodeW = 4;
    localparam int unsigned NocIdW   = 4;
    localparam int unsigned NocLenW  = 8;
    localparam int unsigned NocAddrW = 32;

    // Header fields, packed from the payload MSB downwards. For a 128-bit
    // payload: dst [127:124], src [123:120], pkt_type [119:117], len [116:109],
    // id [108:105], addr [104:73], resp [72:71]; bits below are zero.
    typedef struct packed {
        logic [NocNodeW-1:0] dst;
        logic [NocNodeW-1:0] src;
        logic [2:0]          pkt_type;
        logic [NocLenW-1:0]  len;
        logic [NocIdW-1:0]   id;
        logic [NocAddrW-1:0] addr;
        logic [1:0]          resp;
    } noc_hdr_t;

    localparam int unsigned HdrW = $bits(noc_hdr_t);

    localparam int unsigned DstLsb  = 124;
    localparam int unsigned SrcLsb  = 120;
    localparam int unsigned TypeLsb = 117;
    localparam int unsigned LenLsb  = 109;
    localparam int unsigned IdLsb   = 105;
    localparam int unsigned AddrLsb = 73;
    localparam int unsigned RespLsb = 71;

    // Flit = {valid, ftype[1:0], payload}
    function automatic int unsigned flit_w(input int unsigned data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/noc_flit_oreg.sv
// One-entry valid/ready output register for NoC flits.
// Holds a flit until the consumer takes it; contents are stable while pending.
// A new flit may be loaded in the same cycle the held one leaves.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i/in_data_i    load request and flit body {ftype, payload}
//   in_ready_o              register free or draining this cycle
//   out_valid_o/out_data_o  held flit
//   out_ready_i             consumer accepts the held flit
module noc_flit_oreg #(
    parameter int unsigned Width = 130
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             vld_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = !vld_q || out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_valid_i && in_ready_o) begin
            vld_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_ready_i) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nsu_axi_rd_bridge.sv
// NoC slave-side read bridge. Accepts a single-flit RD_REQ packet addressed to
// NODE_ID, issues one AXI4 INCR read burst, and returns the data as an RD_RESP
// packet (head, one body flit per beat, tail carrying the accumulated resp) to
// the requesting node. One request outstanding at a time.
// Ports:
//   noc_clk, noc_rst          clock, asynchronous active-high reset
//   noc_in_flit/noc_in_busy   request flit in; busy whenever not idle
//   noc_out_flit/noc_out_ready response flit out (valid = MSB) with ready
//   m_axi_ar*                 AXI4 read address channel (master)
//   m_axi_r*                  AXI4 read data channel (master)
//   drop_pulse                one-cycle pulse per discarded malformed flit
module nsu_axi_rd_bridge
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [3:0]  NODE_ID        = 4'h0,
    parameter int unsigned FLIT_W         = flit_w(DATA_WIDTH)
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [FLIT_W-1:0]         noc_in_flit,
    output logic                      noc_in_busy,
    output logic [FLIT_W-1:0]         noc_out_flit,
    input  logic                      noc_out_ready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic                      drop_pulse
);

    localparam int unsigned PadW = DATA_WIDTH - HdrW;

    typedef enum logic [2:0] {StIdle, StHead, StAr, StData, StTail} state_e;

    state_e state_q, state_d;

    logic [NocNodeW-1:0] src_q;
    logic [NocLenW-1:0]  len_q;
    logic [NocIdW-1:0]   id_q;
    logic [NocAddrW-1:0] addr_q;
    logic [7:0]          beat_q;
    logic [1:0]          resp_max_q;
    logic                resp_err_q;
    logic                tail_sent_q;
    logic                drop_q, drop_d;

    noc_hdr_t             in_hdr;
    noc_hdr_t             out_hdr;
    logic                 in_vld;
    logic [1:0]           in_ftype;
    logic                 req_ok;
    logic                 accept;
    logic                 push;
    logic [DATA_WIDTH+1:0] push_data;
    logic                 oreg_in_ready;
    logic                 out_vld;
    logic [DATA_WIDTH+1:0] out_data;
    logic                 r_fire;
    logic [1:0]           resp_final;

    function automatic logic [DATA_WIDTH-1:0] pack_hdr(input noc_hdr_t h);
        return {h, {PadW{1'b0}}};
    endfunction

    assign in_vld   = noc_in_flit[FLIT_W-1];
    assign in_ftype = noc_in_flit[FLIT_W-2 -: 2];
    assign in_hdr   = noc_in_flit[DATA_WIDTH-1 -: HdrW];
    assign req_ok   = in_vld && (in_ftype == FtSingle) && (in_hdr.pkt_type == PktRdReq)
                      && (in_hdr.dst == NODE_ID);

    // Payload bits below the header and the request's resp field carry nothing
    logic unused_in;
    assign unused_in = ^{noc_in_flit[PadW-1:0], in_hdr.resp};

    assign r_fire     = m_axi_rvalid && m_axi_rready;
    // A protocol error overrides whatever the slave reported
    assign resp_final = resp_err_q ? 2'b10 : resp_max_q;

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        push             = 1'b0;
        push_data        = '0;
        drop_d           = 1'b0;
        out_hdr          = '0;
        out_hdr.src      = NODE_ID;
        out_hdr.pkt_type = PktRdResp;
        unique case (state_q)
            StIdle: begin
                if (req_ok) begin
                    // Head goes straight into the (empty) output register
                    accept       = 1'b1;
                    out_hdr.dst  = in_hdr.src;
                    out_hdr.len  = in_hdr.len;
                    out_hdr.id   = in_hdr.id;
                    out_hdr.addr = in_hdr.addr;
                    push         = 1'b1;
                    push_data    = {FtHead, pack_hdr(out_hdr)};
                    state_d      = StHead;
                end else if (in_vld) begin
                    drop_d = 1'b1;
                end
            end
            StHead: begin
                if (out_vld && noc_out_ready) state_d = StAr;
            end
            StAr: begin
                if (m_axi_arready) state_d = StData;
            end
            StData: begin
                if (r_fire) begin
                    push      = 1'b1;
                    push_data = {FtBody, m_axi_rdata};
                    if (m_axi_rlast) state_d = StTail;
                end
            end
            StTail: begin
                if (!tail_sent_q) begin
                    if (oreg_in_ready) begin
                        out_hdr.dst  = src_q;
                        out_hdr.len  = len_q;
                        out_hdr.id   = id_q;
                        out_hdr.addr = addr_q;
                        out_hdr.resp = resp_final;
                        push         = 1'b1;
                        push_data    = {FtTail, pack_hdr(out_hdr)};
                    end
                end else if (out_vld && noc_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q     <= StIdle;
            src_q       <= '0;
            len_q       <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            resp_max_q  <= '0;
            resp_err_q  <= 1'b0;
            tail_sent_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (accept) begin
                src_q       <= in_hdr.src;
                len_q       <= in_hdr.len;
                id_q        <= in_hdr.id;
                addr_q      <= in_hdr.addr;
                beat_q      <= '0;
                resp_max_q  <= '0;
                resp_err_q  <= 1'b0;
                tail_sent_q <= 1'b0;
            end
            if (r_fire) begin
                beat_q <= beat_q + 8'd1;
                if (m_axi_rresp > resp_max_q) resp_max_q <= m_axi_rresp;
                // beat_q is the index of the current beat; rlast must land on len
                if ((NocIdW'(m_axi_rid) != id_q) || (m_axi_rlast && (beat_q != len_q))) begin
                    resp_err_q <= 1'b1;
                end
            end
            if ((state_q == StTail) && push) tail_sent_q <= 1'b1;
        end
    end

    noc_flit_oreg #(
        .Width(DATA_WIDTH + 2)
    ) u_oreg (
        .clk_i      (noc_clk),
        .rst_i      (noc_rst),
        .in_valid_i (push),
        .in_data_i  (push_data),
        .in_ready_o (oreg_in_ready),
        .out_valid_o(out_vld),
        .out_data_o (out_data),
        .out_ready_i(noc_out_ready)
    );

    assign noc_out_flit  = {out_vld, out_data};
    assign noc_in_busy   = (state_q != StIdle);
    assign drop_pulse    = drop_q;

    assign m_axi_arvalid = (state_q == StAr);
    assign m_axi_arid    = AXI_ID_WIDTH'(id_q);
    assign m_axi_araddr  = AXI_ADDR_WIDTH'(addr_q);
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    // Only take a beat when the output register can absorb it this cycle
    assign m_axi_rready  = (state_q == StData) && oreg_in_ready;

endmodule
